// File: rtl/ime_mv_cost_pkg.sv
// Shared constants and width helpers for the IME motion-vector rate-cost pipe.
// Optional window-minimum tracker is enabled with IME_MV_COST_BEST_EN.
package ime_mv_cost_pkg;

    localparam int SE_LEN_W   = 5;
    localparam int BITS_W     = 6;
    localparam int DEF_COST_W = 14;

    function automatic int mvd_width(input int imv_w, input int mvp_w);
        return ((imv_w + 2 > mvp_w) ? imv_w + 2 : mvp_w) + 1;
    endfunction

    function automatic int sat_max(input int w);
        return (1 << w) - 1;
    endfunction

    localparam int COST_MAX = sat_max(DEF_COST_W);

endpackage

// File: rtl/ime_se_len.sv
// Signed Exp-Golomb code length of one mvd component.
// k = codeNum+1; length = 2*floor(log2 k)+1.
module ime_se_len
    import ime_mv_cost_pkg::*;
#(
    parameter int W = 11
) (
    input  logic signed [W-1:0]        mvd,
    output logic        [SE_LEN_W-1:0] len
);

    logic [W-1:0]        mag;
    logic [W:0]          k;
    logic [SE_LEN_W-1:0] msb;
    logic                pos;

    always_comb begin
        pos = !mvd[W-1] && (|mvd);
        mag = mvd[W-1] ? (~mvd + 1'b1) : mvd;
        k   = {mag, !pos};
        msb = '0;
        for (int i = 1; i <= W; i++) begin
            if (k[i]) msb = SE_LEN_W'(i);
        end
        len = {msb[SE_LEN_W-2:0], 1'b1};
    end

endmodule

// File: rtl/ime_mv_cost_pipe.sv
// Three-stage multi-lane MV rate-cost engine with valid/ready backpressure.
// Define IME_MV_COST_BEST_EN to add the output-side window-minimum tracker.
module ime_mv_cost_pipe
    import ime_mv_cost_pkg::*;
#(
    parameter int LANES    = 16,
    parameter int IMV_W    = 7,
    parameter int MVP_W    = 10,
    parameter int LAMBDA_W = 9,
    parameter int COST_W   = DEF_COST_W
`ifdef IME_MV_COST_BEST_EN
    ,
    parameter int BEAT_W   = 8
`endif
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic                      in_last_i,
    input  logic [LAMBDA_W-1:0]       lambda_i,
    input  logic [MVP_W-1:0]          mvp_x_i,
    input  logic [MVP_W-1:0]          mvp_y_i,
    input  logic [LANES*IMV_W-1:0]    mv_x_i,
    input  logic [LANES*IMV_W-1:0]    mv_y_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic                      out_last_o,
    output logic [LANES*COST_W-1:0]   cost_o
`ifdef IME_MV_COST_BEST_EN
    ,
    output logic                      best_valid_o,
    output logic [COST_W-1:0]         best_cost_o,
    output logic [BEAT_W-1:0]         best_beat_o,
    output logic [$clog2(LANES)-1:0]  best_lane_o
`endif
);

    localparam int MVD_W  = mvd_width(IMV_W, MVP_W);
    localparam int PROD_W = BITS_W + LAMBDA_W;
    localparam int CMAX   = (COST_W == DEF_COST_W) ? COST_MAX : sat_max(COST_W);

    logic adv;
    assign adv        = !out_valid_o | out_ready_i;
    assign in_ready_o = adv;

    logic                       v0, last0;
    logic [LAMBDA_W-1:0]        lam0;
    logic signed [MVD_W-1:0]    dx0 [LANES];
    logic signed [MVD_W-1:0]    dy0 [LANES];
    logic signed [MVD_W-1:0]    dx_in [LANES];
    logic signed [MVD_W-1:0]    dy_in [LANES];
    logic signed [MVD_W-1:0]    px, py;

    logic                       v1, last1;
    logic [LAMBDA_W-1:0]        lam1;
    logic [BITS_W-1:0]          bits1 [LANES];
    logic [BITS_W-1:0]          bits_in [LANES];
    logic [LANES*COST_W-1:0]    cost_next;

    assign px = {{(MVD_W-MVP_W){mvp_x_i[MVP_W-1]}}, mvp_x_i};
    assign py = {{(MVD_W-MVP_W){mvp_y_i[MVP_W-1]}}, mvp_y_i};

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [IMV_W-1:0]    mx, my;
        logic [SE_LEN_W-1:0] lx, ly;
        logic [PROD_W-1:0]   prod;

        assign mx = mv_x_i[g*IMV_W +: IMV_W];
        assign my = mv_y_i[g*IMV_W +: IMV_W];
        // Integer-pel candidate is scaled to quarter-pel before subtraction.
        assign dx_in[g] = {{(MVD_W-IMV_W-2){mx[IMV_W-1]}}, mx, 2'b00} - px;
        assign dy_in[g] = {{(MVD_W-IMV_W-2){my[IMV_W-1]}}, my, 2'b00} - py;

        ime_se_len #(.W(MVD_W)) u_len_x (.mvd(dx0[g]), .len(lx));
        ime_se_len #(.W(MVD_W)) u_len_y (.mvd(dy0[g]), .len(ly));

        assign bits_in[g] = BITS_W'(lx) + BITS_W'(ly);
        assign prod = PROD_W'(bits1[g]) * PROD_W'(lam1);
        assign cost_next[g*COST_W +: COST_W] =
            (prod > PROD_W'(CMAX)) ? COST_W'(CMAX) : COST_W'(prod);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v0          <= 1'b0;
            last0       <= 1'b0;
            lam0        <= '0;
            v1          <= 1'b0;
            last1       <= 1'b0;
            lam1        <= '0;
            out_valid_o <= 1'b0;
            out_last_o  <= 1'b0;
            cost_o      <= '0;
            for (int i = 0; i < LANES; i++) begin
                dx0[i]   <= '0;
                dy0[i]   <= '0;
                bits1[i] <= '0;
            end
        end else if (adv) begin
            v0          <= in_valid_i;
            last0       <= in_valid_i & in_last_i;
            lam0        <= lambda_i;
            v1          <= v0;
            last1       <= last0;
            lam1        <= lam0;
            out_valid_o <= v1;
            out_last_o  <= last1;
            cost_o      <= cost_next;
            for (int i = 0; i < LANES; i++) begin
                dx0[i]   <= dx_in[i];
                dy0[i]   <= dy_in[i];
                bits1[i] <= bits_in[i];
            end
        end
    end

`ifdef IME_MV_COST_BEST_EN
    localparam int LANE_W = $clog2(LANES);

    logic              hs, fresh, take;
    logic [COST_W-1:0] bmin, run_cost, nx_cost;
    logic [LANE_W-1:0] blane, run_lane, nx_lane;
    logic [BEAT_W-1:0] beat_cnt, cur_beat, run_beat, nx_beat;

    assign hs = out_valid_o & out_ready_i;

    // Strict compares keep the earliest lane and beat on ties.
    always_comb begin
        bmin  = cost_o[COST_W-1:0];
        blane = '0;
        for (int i = 1; i < LANES; i++) begin
            if (cost_o[i*COST_W +: COST_W] < bmin) begin
                bmin  = cost_o[i*COST_W +: COST_W];
                blane = LANE_W'(i);
            end
        end
        cur_beat = fresh ? '0 : beat_cnt;
        take     = fresh | (bmin < run_cost);
        nx_cost  = take ? bmin : run_cost;
        nx_lane  = take ? blane : run_lane;
        nx_beat  = take ? cur_beat : run_beat;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fresh        <= 1'b1;
            beat_cnt     <= '0;
            run_cost     <= '0;
            run_lane     <= '0;
            run_beat     <= '0;
            best_valid_o <= 1'b0;
            best_cost_o  <= '0;
            best_lane_o  <= '0;
            best_beat_o  <= '0;
        end else begin
            best_valid_o <= hs & out_last_o;
            if (hs) begin
                fresh    <= out_last_o;
                beat_cnt <= cur_beat + 1'b1;
                run_cost <= nx_cost;
                run_lane <= nx_lane;
                run_beat <= nx_beat;
                if (out_last_o) begin
                    best_cost_o <= nx_cost;
                    best_lane_o <= nx_lane;
                    best_beat_o <= nx_beat;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_ime_mv_cost_pipe.sv
// Directed self-checking bench for ime_mv_cost_pipe.
// Tracker scenario is compiled in with IME_MV_COST_BEST_EN.
module tb_ime_mv_cost_pipe;

    localparam int LANES    = 16;
    localparam int IMV_W    = 7;
    localparam int MVP_W    = 10;
    localparam int LAMBDA_W = 9;
    localparam int COST_W   = 14;
    localparam int BEAT_W   = 8;

    logic                    clk = 1'b0;
    logic                    rstn;
    logic                    in_valid_i;
    logic                    in_ready_o;
    logic                    in_last_i;
    logic [LAMBDA_W-1:0]     lambda_i;
    logic [MVP_W-1:0]        mvp_x_i;
    logic [MVP_W-1:0]        mvp_y_i;
    logic [LANES*IMV_W-1:0]  mv_x_i;
    logic [LANES*IMV_W-1:0]  mv_y_i;
    logic                    out_valid_o;
    logic                    out_ready_i;
    logic                    out_last_o;
    logic [LANES*COST_W-1:0] cost_o;
`ifdef IME_MV_COST_BEST_EN
    logic                    best_valid_o;
    logic [COST_W-1:0]       best_cost_o;
    logic [BEAT_W-1:0]       best_beat_o;
    logic [3:0]              best_lane_o;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ime_mv_cost_pipe dut (
        .clk         (clk),
        .rstn        (rstn),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_last_i   (in_last_i),
        .lambda_i    (lambda_i),
        .mvp_x_i     (mvp_x_i),
        .mvp_y_i     (mvp_y_i),
        .mv_x_i      (mv_x_i),
        .mv_y_i      (mv_y_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_last_o  (out_last_o),
        .cost_o      (cost_o)
`ifdef IME_MV_COST_BEST_EN
        ,
        .best_valid_o(best_valid_o),
        .best_cost_o (best_cost_o),
        .best_beat_o (best_beat_o),
        .best_lane_o (best_lane_o)
`endif
    );

    function automatic logic [LANES*IMV_W-1:0] rep(input logic [IMV_W-1:0] v);
        logic [LANES*IMV_W-1:0] r;
        for (int i = 0; i < LANES; i++) r[i*IMV_W +: IMV_W] = v;
        return r;
    endfunction

    function automatic int lane_cost(input int i);
        return int'(cost_o[i*COST_W +: COST_W]);
    endfunction

    task automatic set_beat(input int lam, input logic [MVP_W-1:0] px,
                            input logic [MVP_W-1:0] py,
                            input logic [LANES*IMV_W-1:0] mx,
                            input logic [LANES*IMV_W-1:0] my,
                            input logic last);
        lambda_i  = LAMBDA_W'(lam);
        mvp_x_i   = px;
        mvp_y_i   = py;
        mv_x_i    = mx;
        mv_y_i    = my;
        in_last_i = last;
    endtask

    // Accept one beat into an idle pipe and stop where it is on the output.
    task automatic send_wait();
        in_valid_i = 1'b1;
        @(posedge clk); #1;
        in_valid_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++;
        if (out_valid_o !== 1'b0 || out_last_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags valid=%b last=%b want 0 0", out_valid_o, out_last_o);
        end
        checks++;
        if (cost_o !== '0) begin
            errors++;
            $display("FAIL reset_cost got %h want 0", cost_o);
        end
        checks++;
        if (in_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %b want 1", in_ready_o);
        end
`ifdef IME_MV_COST_BEST_EN
        checks++;
        if (best_valid_o !== 1'b0 || best_cost_o !== '0 ||
            best_beat_o !== '0 || best_lane_o !== '0) begin
            errors++;
            $display("FAIL reset_best v=%b c=%0d b=%0d l=%0d want all 0",
                     best_valid_o, best_cost_o, best_beat_o, best_lane_o);
        end
`endif
    endtask

    task automatic test_zero_mv();
        set_beat(4, '0, '0, '0, '0, 1'b0);
        in_valid_i = 1'b1;
        @(posedge clk); #1;
        in_valid_i = 1'b0;
        checks++;
        if (out_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL zero_lat1 valid=%b want 0", out_valid_o);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL zero_lat2 valid=%b want 0", out_valid_o);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid_o !== 1'b1 || out_last_o !== 1'b0) begin
            errors++;
            $display("FAIL zero_lat3 valid=%b last=%b want 1 0", out_valid_o, out_last_o);
        end
        for (int i = 0; i < LANES; i++) begin
            checks++;
            if (lane_cost(i) !== 8) begin
                errors++;
                $display("FAIL zero_cost lane%0d got %0d want 8", i, lane_cost(i));
            end
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL zero_nodup valid=%b want 0", out_valid_o);
        end
    endtask

    task automatic test_unit_mv();
        set_beat(10, '0, '0, rep(7'd1), rep(7'h7f), 1'b0);
        send_wait();
        checks++;
        if (out_valid_o !== 1'b1 || lane_cost(0) !== 140 || lane_cost(7) !== 140) begin
            errors++;
            $display("FAIL unit_cost v=%b l0=%0d l7=%0d want 1 140 140",
                     out_valid_o, lane_cost(0), lane_cost(7));
        end
    endtask

    task automatic test_mvp();
        // mvd_x=-3 -> len 5, mvd_y=+5 -> len 7, 12*7=84
        set_beat(7, 10'd3, 10'h3fb, '0, '0, 1'b0);
        send_wait();
        checks++;
        if (lane_cost(0) !== 84 || lane_cost(15) !== 84) begin
            errors++;
            $display("FAIL mvp_cost l0=%0d l15=%0d want 84", lane_cost(0), lane_cost(15));
        end
    endtask

    task automatic test_saturate();
        set_beat(511, 10'h1ff, 10'h1ff, rep(7'h40), rep(7'h40), 1'b0);
        send_wait();
        checks++;
        if (lane_cost(0) !== 16383 || lane_cost(15) !== 16383) begin
            errors++;
            $display("FAIL sat_511 l0=%0d l15=%0d want 16383", lane_cost(0), lane_cost(15));
        end
        set_beat(390, 10'h1ff, 10'h1ff, rep(7'h40), rep(7'h40), 1'b0);
        send_wait();
        checks++;
        if (lane_cost(3) !== 16380) begin
            errors++;
            $display("FAIL sat_390 got %0d want 16380", lane_cost(3));
        end
        set_beat(0, 10'h1ff, 10'h1ff, rep(7'h40), rep(7'h40), 1'b0);
        send_wait();
        checks++;
        if (lane_cost(9) !== 0) begin
            errors++;
            $display("FAIL lambda0 got %0d want 0", lane_cost(9));
        end
    endtask

    task automatic test_lanes();
        int exp_c [LANES] = '{2, 8, 10, 10, 12, 12, 12, 12,
                              14, 14, 14, 14, 14, 14, 14, 14};
        logic [LANES*IMV_W-1:0] mx;
        for (int i = 0; i < LANES; i++) mx[i*IMV_W +: IMV_W] = IMV_W'(i);
        set_beat(1, '0, '0, mx, '0, 1'b0);
        send_wait();
        for (int i = 0; i < LANES; i++) begin
            checks++;
            if (lane_cost(i) !== exp_c[i]) begin
                errors++;
                $display("FAIL lanes lane%0d got %0d want %0d", i, lane_cost(i), exp_c[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int  exp_c [3] = '{2, 4, 6};
        logic exp_l [3] = '{1'b0, 1'b0, 1'b1};
        for (int b = 0; b < 3; b++) begin
            set_beat(b + 1, '0, '0, '0, '0, exp_l[b]);
            in_valid_i = 1'b1;
            @(posedge clk); #1;
        end
        in_valid_i = 1'b0;
        for (int b = 0; b < 3; b++) begin
            checks++;
            if (out_valid_o !== 1'b1 || lane_cost(0) !== exp_c[b] ||
                out_last_o !== exp_l[b]) begin
                errors++;
                $display("FAIL b2b beat%0d v=%b c=%0d l=%b want 1 %0d %b",
                         b, out_valid_o, lane_cost(0), out_last_o, exp_c[b], exp_l[b]);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (out_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain valid=%b want 0", out_valid_o);
        end
    endtask

    task automatic test_backpressure();
        int n = 0;
        logic acc;
        out_ready_i = 1'b0;
        for (int b = 0; b < 3; b++) begin
            set_beat(b + 1, '0, '0, '0, '0, 1'b0);
            in_valid_i = 1'b1;
            checks++;
            if (in_ready_o !== 1'b1) begin
                errors++;
                $display("FAIL bp_fill beat%0d ready=%b want 1", b, in_ready_o);
            end
            @(posedge clk); #1;
        end
        set_beat(4, '0, '0, '0, '0, 1'b1);
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (in_ready_o !== 1'b0 || out_valid_o !== 1'b1 || lane_cost(0) !== 2 ||
                out_last_o !== 1'b0) begin
                errors++;
                $display("FAIL bp_stall cyc%0d rdy=%b v=%b c=%0d l=%b want 0 1 2 0",
                         c, in_ready_o, out_valid_o, lane_cost(0), out_last_o);
            end
            @(posedge clk); #1;
        end
        out_ready_i = 1'b1;
        for (int c = 0; c < 20 && n < 4; c++) begin
            acc = in_valid_i & in_ready_o;
            if (out_valid_o) begin
                checks++;
                if (lane_cost(0) !== 2 * (n + 1) || lane_cost(15) !== 2 * (n + 1) ||
                    out_last_o !== (n == 3)) begin
                    errors++;
                    $display("FAIL bp_order beat%0d c=%0d/%0d l=%b want %0d last %0d",
                             n, lane_cost(0), lane_cost(15), out_last_o, 2 * (n + 1), n == 3);
                end
                n++;
            end
            @(posedge clk); #1;
            if (acc) in_valid_i = 1'b0;
        end
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL bp_count got %0d beats want 4", n);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL bp_extra valid=%b want 0", out_valid_o);
        end
    endtask

    task automatic test_async_reset();
        out_ready_i = 1'b1;
        set_beat(5, '0, '0, '0, '0, 1'b0);
        in_valid_i = 1'b1;
        @(posedge clk); #1;
        set_beat(6, '0, '0, '0, '0, 1'b0);
        @(posedge clk); #1;
        in_valid_i = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (out_valid_o !== 1'b1 || lane_cost(0) !== 10) begin
            errors++;
            $display("FAIL ar_pre v=%b c=%0d want 1 10", out_valid_o, lane_cost(0));
        end
        #2 rstn = 1'b0;
        #1;
        checks++;
        if (out_valid_o !== 1'b0 || cost_o !== '0) begin
            errors++;
            $display("FAIL ar_immediate v=%b c=%h want 0 0", out_valid_o, cost_o);
        end
        set_beat(7, '0, '0, '0, '0, 1'b1);
        in_valid_i = 1'b1;
        repeat (2) @(posedge clk);
        #3 rstn = 1'b1;
        #1;
        checks++;
        if (in_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL ar_ready got %b want 1", in_ready_o);
        end
        @(posedge clk); #1;
        in_valid_i = 1'b0;
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (out_valid_o !== 1'b0) begin
                errors++;
                $display("FAIL ar_stale cyc%0d valid=%b want 0", c, out_valid_o);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (out_valid_o !== 1'b1 || lane_cost(0) !== 14 || out_last_o !== 1'b1) begin
            errors++;
            $display("FAIL ar_first v=%b c=%0d l=%b want 1 14 1",
                     out_valid_o, lane_cost(0), out_last_o);
        end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid_o !== 1'b0) begin
                errors++;
                $display("FAIL ar_after cyc%0d valid=%b want 0", c, out_valid_o);
            end
        end
    endtask

`ifdef IME_MV_COST_BEST_EN
    task automatic test_best();
        logic [LANES*IMV_W-1:0] mx;
        int pulses = 0;
        out_ready_i = 1'b1;
        set_beat(1, '0, '0, rep(7'd2), '0, 1'b0);
        in_valid_i = 1'b1;
        @(posedge clk); #1;
        mx = rep(7'd1);
        mx[5*IMV_W +: IMV_W] = '0;
        set_beat(1, '0, '0, mx, '0, 1'b0);
        @(posedge clk); #1;
        mx = rep(7'd1);
        mx[IMV_W-1:0] = '0;
        set_beat(1, '0, '0, mx, '0, 1'b1);
        @(posedge clk); #1;
        in_valid_i = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (best_valid_o === 1'b1) begin
                pulses++;
                checks++;
                if (best_cost_o !== 2 || best_beat_o !== 1 || best_lane_o !== 5) begin
                    errors++;
                    $display("FAIL best_value c=%0d b=%0d l=%0d want 2 1 5",
                             best_cost_o, best_beat_o, best_lane_o);
                end
            end
            @(posedge clk); #1;
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL best_pulses got %0d want 1", pulses);
        end
        checks++;
        if (best_cost_o !== 2 || best_beat_o !== 1 || best_lane_o !== 5) begin
            errors++;
            $display("FAIL best_hold c=%0d b=%0d l=%0d want 2 1 5",
                     best_cost_o, best_beat_o, best_lane_o);
        end
    endtask
`endif

    initial begin
        rstn        = 1'b0;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        set_beat(0, '0, '0, '0, '0, 1'b0);
        #1;
        test_reset();
        @(posedge clk);
        #3 rstn = 1'b1;
        @(posedge clk); #1;
        test_zero_mv();
        test_unit_mv();
        test_mvp();
        test_saturate();
        test_lanes();
        test_back_to_back();
        test_backpressure();
        test_async_reset();
`ifdef IME_MV_COST_BEST_EN
        test_best();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
